// File: rtl/mul_pipe_pkg.sv
// Shared types and helpers for the multiplier pipeline datapath blocks.
//   shw(width) : shift-amount width able to express every shift up to and
//                beyond a full {data, guard, round} flush (width + 2).
//   grs_t      : guard / round / sticky bundle, packed as {g, r, s}.
package mul_pipe_pkg;

  typedef struct packed {
    logic g;
    logic r;
    logic s;
  } grs_t;

  function automatic int shw(input int width);
    return $clog2(width + 3);
  endfunction

endpackage

// File: rtl/shifter_r_stage.sv
// Combinational logical right shift by the shift-amount bits [HI:LO].
// The partial amount carries those bits at their true weight, so an
// instance covering the upper bits shifts in multiples of 2**LO.
// Ports:
//   din     in  W         vector to shift
//   sh      in  HI-LO+1   shift-amount bits [HI:LO]
//   dout    out W         din >> ({sh, LO zeros}), zero fill
//   dropped out 1         OR of every bit shifted out at the bottom
module shifter_r_stage #(
  parameter int W  = 50,
  parameter int LO = 0,
  parameter int HI = 2
) (
  input  logic [W-1:0]  din,
  input  logic [HI-LO:0] sh,
  output logic [W-1:0]  dout,
  output logic          dropped
);

  logic [HI:0]  amt;
  logic [W-1:0] drop_mask;

  // Shift and collect the bits falling off the bottom. Amounts of W or more
  // give an all-zero result and an all-ones mask, so saturation needs no
  // special case and nothing is ever indexed out of range.
  always_comb begin
    amt        = '0;
    amt[HI:LO] = sh;
    dout       = din >> amt;
    drop_mask  = ~({W{1'b1}} << amt);
    dropped    = |(din & drop_mask);
  end

endmodule

// File: rtl/shifter_r_sticky_pipe.sv
// Two-stage pipelined logical right shifter with guard/round/sticky capture.
// The operand is extended with two zero bits (guard, round); stage A applies
// the upper shift bits, stage B the low SPLIT bits, and every bit shifted out
// below the round position is ORed into sticky. Global-stall flow control.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   data_in, shift_num  operand and right-shift amount
//   tag_in / tag_out    sideband carried with the beat
//   out_valid/out_ready output handshake
//   data_out, grs       shifted result and {guard, round, sticky}
module shifter_r_sticky_pipe
  import mul_pipe_pkg::*;
#(
  parameter  int WIDTH = 48,
  parameter  int SPLIT = 3,
  parameter  int TAGW  = 8,
  localparam int SW    = shw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SW-1:0]    shift_num,
  input  logic [TAGW-1:0]  tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic [2:0]       grs,
  output logic [TAGW-1:0]  tag_out
);

  localparam int EW = WIDTH + 2;

  logic             en;
  logic [EW-1:0]    sa_vec;
  logic             sa_drop;
  logic [EW-1:0]    sb_vec;
  logic             sb_drop;

  logic             a_valid;
  logic [EW-1:0]    a_vec;
  logic             a_sticky;
  logic [SPLIT-1:0] a_lo;
  logic [TAGW-1:0]  a_tag;

  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  grs_t             b_grs;
  logic [TAGW-1:0]  b_tag;

  shifter_r_stage #(.W(EW), .LO(SPLIT), .HI(SW - 1)) u_stage_a (
    .din     ({data_in, 2'b00}),
    .sh      (shift_num[SW-1:SPLIT]),
    .dout    (sa_vec),
    .dropped (sa_drop)
  );

  shifter_r_stage #(.W(EW), .LO(0), .HI(SPLIT - 1)) u_stage_b (
    .din     (a_vec),
    .sh      (a_lo),
    .dout    (sb_vec),
    .dropped (sb_drop)
  );

  // A full output register that is not being drained freezes the whole pipe.
  assign en        = ~b_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = b_valid;
  assign data_out  = b_data;
  assign grs       = b_grs;
  assign tag_out   = b_tag;

  // Pipeline registers: both banks advance together whenever en is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid  <= 1'b0;
      a_vec    <= '0;
      a_sticky <= 1'b0;
      a_lo     <= '0;
      a_tag    <= '0;
      b_valid  <= 1'b0;
      b_data   <= '0;
      b_grs    <= '0;
      b_tag    <= '0;
    end else if (en) begin
      a_valid  <= in_valid;
      a_vec    <= sa_vec;
      a_sticky <= sa_drop;
      a_lo     <= shift_num[SPLIT-1:0];
      a_tag    <= tag_in;
      b_valid  <= a_valid;
      b_data   <= sb_vec[EW-1:2];
      b_grs    <= '{g: sb_vec[1], r: sb_vec[0], s: a_sticky | sb_drop};
      b_tag    <= a_tag;
    end
  end

endmodule
